// File: rtl/control_param.sv
// Parametrised instruction sequencer/decoder driving PC, register file, ALU, data memory and IO.
// Optional MULT_HI_EN macro adds a MUL_WB state that writes the high half of a 0x6? multiply.
module control_param #(
  parameter int                DATA_W   = 8,
  parameter int                PC_W     = 8,
  parameter int                IO_CH    = 1,
  parameter int                ALU_LAT  = 3,
  parameter logic [DATA_W-1:0] BRK_CODE = 'hF0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_W-1:0]       instr,
  input  logic [2*DATA_W-1:0]     result,
  input  logic                    zo,
  input  logic                    no,
  input  logic                    co,
  input  logic [DATA_W-1:0]       rd_data,
  input  logic [DATA_W-1:0]       rr_data,
  input  logic [DATA_W-1:0]       data_mem,
  input  logic                    mem_ready,
  output logic                    inc,
  output logic                    jmp,
  output logic                    call,
  output logic                    ret,
  output logic [PC_W-1:0]         instaddr,
  output logic [7:0]              opcode,
  output logic                    cin,
  output logic [1:0]              rd_addr,
  output logic [1:0]              rr_addr,
  output logic                    wr_en,
  output logic [DATA_W-1:0]       data_reg_o,
  output logic                    mem_req,
  output logic                    data_wr_en,
  output logic [DATA_W-1:0]       data_addr,
  output logic [DATA_W-1:0]       data_mem_o,
  output logic [IO_CH*DATA_W-1:0] io_o,
  output logic                    halted
);

  typedef enum logic [4:0] {
    S_DECODE    = 5'd0,
    S_CMD_WAIT  = 5'd1,
    S_CMD_EXEC  = 5'd2,
    S_SETTLE1   = 5'd3,
    S_SETTLE2   = 5'd4,
    S_ALU_WAIT  = 5'd5,
    S_ALU_WB    = 5'd6,
    S_LD_WAIT   = 5'd7,
    S_LD_WB     = 5'd8,
    S_LD_SETTLE = 5'd9,
    S_MEM_RD    = 5'd10,
    S_MEM_WR    = 5'd11,
    S_IO_WR     = 5'd12,
    S_NOOP1     = 5'd13,
    S_NOOP2     = 5'd14,
    S_BRK       = 5'd15
`ifdef MULT_HI_EN
    ,
    S_MUL_WB    = 5'd16
`endif
  } state_t;

  state_t                         state_q, state_d;
  logic [7:0]                     ir_q, ir_d;
  logic [3:0]                     alu_cnt_q, alu_cnt_d;
  logic [IO_CH-1:0][DATA_W-1:0]   io_q, io_d;
  logic                           io_fire;
  logic                           brk_active;
  logic [31:0]                    io_sel;

  function automatic state_t dispatch(input logic [7:0] op);
    state_t s;
    s = S_ALU_WAIT;
    case (op[7:4])
      4'h4, 4'h5: s = S_CMD_WAIT;
      4'h3:       s = S_LD_WAIT;
      4'h2:       s = S_MEM_RD;
      4'h1:       s = S_MEM_WR;
      4'h7: begin
        if (op[3:2] == 2'b00) s = S_IO_WR;
        else if (op == 8'h7C) s = S_NOOP1;
        else if (op == 8'h7F) s = S_BRK;
        else                  s = S_ALU_WAIT;
      end
      default:    s = S_ALU_WAIT;
    endcase
    return s;
  endfunction

  assign io_sel = 32'(rr_data) % 32'(IO_CH);

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    alu_cnt_d  = '0;
    io_fire    = 1'b0;
    brk_active = 1'b0;
    inc        = 1'b0;
    jmp        = 1'b0;
    call       = 1'b0;
    ret        = 1'b0;
    instaddr   = '0;
    opcode     = '0;
    cin        = 1'b0;
    rd_addr    = '0;
    rr_addr    = '0;
    wr_en      = 1'b0;
    data_reg_o = '0;
    mem_req    = 1'b0;
    data_wr_en = 1'b0;
    data_addr  = '0;
    data_mem_o = '0;
    halted     = 1'b0;

    // Outputs are forced quiet while reset is asserted, even though the state register sits in DECODE.
    if (rst_n) begin
      case (state_q)
        S_DECODE: begin
          inc     = 1'b1;
          ir_d    = instr[7:0];
          state_d = dispatch(instr[7:0]);
        end
        S_CMD_WAIT: state_d = S_CMD_EXEC;
        S_CMD_EXEC: begin
          instaddr = instr[PC_W-1:0];
          if (ir_q == 8'h50)                                   call = 1'b1;
          else if (ir_q == 8'h58)                              ret  = 1'b1;
          else if (ir_q == 8'h40)                              jmp  = 1'b1;
          else if (ir_q[7:4] == 4'h4 && |(ir_q[2:0] & {co, zo, no})) jmp = 1'b1;
          else                                                 inc  = 1'b1;
          state_d = S_SETTLE1;
        end
        S_SETTLE1: state_d = S_SETTLE2;
        S_SETTLE2: state_d = S_DECODE;
        S_ALU_WAIT: begin
          opcode  = ir_q;
          rd_addr = ir_q[3:2];
          rr_addr = ir_q[1:0];
          cin     = co;
          if (alu_cnt_q == 4'(ALU_LAT - 1)) begin
            state_d = S_ALU_WB;
          end else begin
            alu_cnt_d = alu_cnt_q + 4'd1;
          end
        end
        S_ALU_WB: begin
          opcode     = ir_q;
          rd_addr    = ir_q[3:2];
          rr_addr    = ir_q[1:0];
          cin        = co;
          wr_en      = 1'b1;
          data_reg_o = result[DATA_W-1:0];
`ifdef MULT_HI_EN
          state_d    = (ir_q[7:4] == 4'h6) ? S_MUL_WB : S_DECODE;
`else
          state_d    = S_DECODE;
`endif
        end
`ifdef MULT_HI_EN
        S_MUL_WB: begin
          opcode     = ir_q;
          cin        = co;
          wr_en      = 1'b1;
          rd_addr    = ir_q[1:0];
          data_reg_o = result[2*DATA_W-1:DATA_W];
          state_d    = S_DECODE;
        end
`endif
        S_LD_WAIT: state_d = S_LD_WB;
        S_LD_WB: begin
          wr_en      = 1'b1;
          rd_addr    = ir_q[3:2];
          data_reg_o = instr;
          inc        = 1'b1;
          state_d    = S_LD_SETTLE;
        end
        S_LD_SETTLE: state_d = S_DECODE;
        S_MEM_RD: begin
          mem_req   = 1'b1;
          data_addr = rr_data;
          rr_addr   = ir_q[1:0];
          if (mem_ready) begin
            wr_en      = 1'b1;
            rd_addr    = ir_q[3:2];
            data_reg_o = data_mem;
            state_d    = S_DECODE;
          end
        end
        S_MEM_WR: begin
          mem_req    = 1'b1;
          data_wr_en = 1'b1;
          data_addr  = rr_data;
          data_mem_o = rd_data;
          rd_addr    = ir_q[3:2];
          rr_addr    = ir_q[1:0];
          if (mem_ready) state_d = S_DECODE;
        end
        S_IO_WR: begin
          mem_req   = 1'b1;
          data_addr = rr_data;
          rr_addr   = ir_q[1:0];
          if (mem_ready) begin
            io_fire = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_NOOP1: state_d = S_NOOP2;
        S_NOOP2: state_d = S_DECODE;
        S_BRK: begin
          halted     = 1'b1;
          brk_active = 1'b1;
        end
        default: state_d = S_DECODE;
      endcase
    end
  end

  for (genvar gi = 0; gi < IO_CH; gi++) begin : g_io
    assign io_d[gi] = (gi == 0 && brk_active)            ? BRK_CODE :
                      (io_fire && io_sel == 32'(gi))      ? data_mem :
                                                            io_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DECODE;
      ir_q      <= '0;
      alu_cnt_q <= '0;
      io_q      <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      alu_cnt_q <= alu_cnt_d;
      io_q      <= io_d;
    end
  end

  assign io_o = io_q;

`ifndef MULT_HI_EN
  // The high product half only has a consumer when the multiply write-back state exists.
  logic mul_hi_unused;
  assign mul_hi_unused = ^result[2*DATA_W-1:DATA_W];
`endif

  if (DATA_W > 8) begin : g_wide_unused
    logic instr_hi_unused;
    assign instr_hi_unused = ^instr[DATA_W-1:8];
  end

endmodule

// File: tb/tb_control_param.sv
// Directed bench for control_param (IO_CH=2): register writes go through an expected-write queue.
module tb_control_param;
  localparam int DW  = 8;
  localparam int PW  = 8;
  localparam int CH  = 2;
  localparam int LAT = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     instr;
  logic [2*DW-1:0]   result;
  logic              zo, no, co;
  logic [DW-1:0]     rd_data, rr_data, data_mem;
  logic              mem_ready;
  logic              inc, jmp, call, ret;
  logic [PW-1:0]     instaddr;
  logic [7:0]        opcode;
  logic              cin;
  logic [1:0]        rd_addr, rr_addr;
  logic              wr_en;
  logic [DW-1:0]     data_reg_o;
  logic              mem_req, data_wr_en;
  logic [DW-1:0]     data_addr, data_mem_o;
  logic [CH*DW-1:0]  io_o;
  logic              halted;

  always #5 clk = ~clk;

  control_param #(
    .DATA_W(DW), .PC_W(PW), .IO_CH(CH), .ALU_LAT(LAT), .BRK_CODE(8'hF0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .result(result),
    .zo(zo), .no(no), .co(co), .rd_data(rd_data), .rr_data(rr_data),
    .data_mem(data_mem), .mem_ready(mem_ready),
    .inc(inc), .jmp(jmp), .call(call), .ret(ret), .instaddr(instaddr),
    .opcode(opcode), .cin(cin), .rd_addr(rd_addr), .rr_addr(rr_addr),
    .wr_en(wr_en), .data_reg_o(data_reg_o), .mem_req(mem_req),
    .data_wr_en(data_wr_en), .data_addr(data_addr), .data_mem_o(data_mem_o),
    .io_o(io_o), .halted(halted)
  );

  typedef struct packed { logic [1:0] rd; logic [7:0] data; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int checks = 0;
  int failures = 0;
  int inc_cnt, jmp_cnt, call_cnt, ret_cnt, req_cnt, act_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clr();
    inc_cnt = 0; jmp_cnt = 0; call_cnt = 0; ret_cnt = 0; req_cnt = 0; act_cnt = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every register write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      inc_cnt  += int'(inc);
      jmp_cnt  += int'(jmp);
      call_cnt += int'(call);
      ret_cnt  += int'(ret);
      req_cnt  += int'(mem_req);
      act_cnt  += int'(inc | jmp | call | ret | wr_en | mem_req | data_wr_en);
      chk("pc_onehot", 32'($countones({inc, jmp, call, ret}) <= 1), 32'd1);
      if (wr_en) begin
        chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_rd_addr", 32'(rd_addr), 32'(mon_e.rd));
          chk("wr_data", 32'(data_reg_o), 32'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr = '0; result = '0; zo = 1'b0; no = 1'b0; co = 1'b0;
    rd_data = '0; rr_data = '0; data_mem = '0; mem_ready = 1'b0;
    clr();
    repeat (2) @(posedge clk);
    #3;
    chk("rst_inc", 32'(inc), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_io", 32'(io_o), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    nxt();
    rst_n = 1'b1;

    // LD 0x34 with operand 0x5A
    clr(); instr = 8'h34; #2 chk("ld_dec_inc", 32'(inc), 32'd1);
    nxt(); instr = 8'h5A;
    nxt(); exp_q.push_back(wr_t'{rd: 2'd1, data: 8'h5A});
    nxt();
    nxt(); #2;
    chk("ld_inc_pulses", inc_cnt, 32'd2);
    chk("ld_drained", exp_q.size(), 32'd0);
    chk("ld_back_decode", 32'(inc), 32'd1);

    // conditional jump taken on zo
    clr(); instr = 8'h42;
    nxt(); instr = 8'h80;
    nxt(); zo = 1'b1; #2;
    chk("jz_jmp", 32'(jmp), 32'd1);
    chk("jz_addr", 32'(instaddr), 32'h80);
    nxt(); zo = 1'b0;
    nxt(); nxt(); #2;
    chk("jz_jmp_cnt", jmp_cnt, 32'd1);
    chk("jz_inc_cnt", inc_cnt, 32'd1);

    // same opcode with zo low: carry set but masked out
    clr(); instr = 8'h42;
    nxt(); instr = 8'h80;
    nxt(); co = 1'b1; #2;
    chk("jnz_jmp", 32'(jmp), 32'd0);
    chk("jnz_inc", 32'(inc), 32'd1);
    nxt(); co = 1'b0;
    nxt(); nxt(); #2;
    chk("jnz_jmp_cnt", jmp_cnt, 32'd0);
    chk("jnz_inc_cnt", inc_cnt, 32'd2);

    // call
    clr(); instr = 8'h50;
    nxt(); instr = 8'h44;
    nxt(); #2;
    chk("call_strobe", 32'(call), 32'd1);
    chk("call_addr", 32'(instaddr), 32'h44);
    nxt(); nxt(); nxt(); #2;
    chk("call_cnt", call_cnt, 32'd1);
    chk("call_inc_cnt", inc_cnt, 32'd1);

    // MEM_RD with 3 stall cycles
    clr(); instr = 8'h21; rr_data = 8'h10; data_mem = 8'h77;
    nxt(); #2;
    chk("rd_req", 32'(mem_req), 32'd1);
    chk("rd_addr_out", 32'(data_addr), 32'h10);
    chk("rd_rr_addr", 32'(rr_addr), 32'd1);
    nxt(); nxt();
    nxt(); mem_ready = 1'b1; exp_q.push_back(wr_t'{rd: 2'd0, data: 8'h77});
    nxt(); mem_ready = 1'b0; #2;
    chk("rd_req_cycles", req_cnt, 32'd4);
    chk("rd_drained", exp_q.size(), 32'd0);
    chk("rd_req_drop", 32'(mem_req), 32'd0);

    // MEM_WR completing in its first cycle
    clr(); instr = 8'h19; rr_data = 8'h33; rd_data = 8'hA5;
    nxt(); mem_ready = 1'b1; #2;
    chk("wr_req", 32'(mem_req), 32'd1);
    chk("wr_wen", 32'(data_wr_en), 32'd1);
    chk("wr_addr", 32'(data_addr), 32'h33);
    chk("wr_wdata", 32'(data_mem_o), 32'hA5);
    chk("wr_rd_sel", 32'(rd_addr), 32'd2);
    nxt(); mem_ready = 1'b0; #2;
    chk("wr_req_drop", 32'(mem_req), 32'd0);
    chk("wr_decode", 32'(inc), 32'd1);

    // ALU multiply 0x61
    clr(); instr = 8'h61; result = 16'hBEEF; co = 1'b1;
    nxt(); #2;
    chk("alu_opcode", 32'(opcode), 32'h61);
    chk("alu_cin", 32'(cin), 32'd1);
    chk("alu_rd", 32'(rd_addr), 32'd0);
    chk("alu_rr", 32'(rr_addr), 32'd1);
    nxt(); nxt(); #2;
    chk("alu_hold", 32'(opcode), 32'h61);
    nxt(); exp_q.push_back(wr_t'{rd: 2'd0, data: 8'hEF});
`ifdef MULT_HI_EN
    nxt(); exp_q.push_back(wr_t'{rd: 2'd1, data: 8'hBE});
`endif
    nxt(); co = 1'b0; #2;
    chk("alu_decode", 32'(inc), 32'd1);
    chk("alu_drained", exp_q.size(), 32'd0);

    // IO channel 1 then channel 0
    clr(); instr = 8'h71; rr_data = 8'h05; data_mem = 8'h3C;
    nxt(); mem_ready = 1'b1; #2;
    chk("io_req", 32'(mem_req), 32'd1);
    chk("io_addr", 32'(data_addr), 32'h05);
    nxt(); mem_ready = 1'b0; #2;
    chk("io_ch1", 32'(io_o), 32'h3C00);
    instr = 8'h70; rr_data = 8'h04; data_mem = 8'h11;
    nxt(); mem_ready = 1'b1;
    nxt(); mem_ready = 1'b0; #2;
    chk("io_ch0", 32'(io_o), 32'h3C11);

    // NOOP
    clr(); instr = 8'h7C;
    nxt(); nxt(); nxt(); #2;
    chk("noop_act", act_cnt, 32'd1);
    chk("noop_decode", 32'(inc), 32'd1);

    // reset asserted mid MEM_WR
    clr(); instr = 8'h10; rr_data = 8'h20; rd_data = 8'h55;
    nxt(); #2;
    chk("mrst_req_before", 32'(mem_req), 32'd1);
    rst_n = 1'b0; #1;
    chk("mrst_req", 32'(mem_req), 32'd0);
    chk("mrst_wen", 32'(data_wr_en), 32'd0);
    chk("mrst_io", 32'(io_o), 32'd0);
    nxt(); rst_n = 1'b1;

    // BRK
    instr = 8'h7F;
    nxt(); #2;
    chk("brk_halted", 32'(halted), 32'd1);
    clr();
    nxt(); #2;
    chk("brk_io", 32'(io_o), 32'h00F0);
    for (int i = 0; i < 20; i++) begin
      nxt();
      mem_ready = ~mem_ready;
      instr = 8'($urandom_range(0, 255));
      #2 chk("brk_hold", 32'(halted), 32'd1);
    end
    chk("brk_quiet", act_cnt, 32'd0);
    rst_n = 1'b0; #1;
    chk("brk_reset_exit", 32'(halted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
